line_window_buffer: RTL and testbench

LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

---
 rtl/line_window_buffer.sv | 206 ++++++++++++++++++++
 tb/tb_line_window_buffer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_window_buffer.sv
// ---------------------------------------------------------------------------
// line_window_buffer
//   Sliding BufferRows x WindowCols pixel window over a raster stream, for
//   InputChannels independent channels that share one line RAM. The RAM holds
//   one "stored column" per line position: the BufferRows-1 previous lines'
//   pixels at that position, newest line in slot 0.
//
//   Pipeline: S1 (input registered, RAM read issued on accept) -> OUT (window
//   register). The RAM location for a position is rewritten when that beat
//   moves from S1 to OUT.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   data_i            one pixel per channel
//   sof_i             first pixel of a frame (qualified by valid_i && ready_o)
//   line_len_i        pixels per line, sampled on an accepted sof_i beat
//   valid_i/ready_o   input handshake
//   data_o            window [ch][row][col]; row 0 = current line, col 0 = newest
//   window_full_o     all window positions hold real frame data
//   valid_o/ready_i   output handshake
// ---------------------------------------------------------------------------
module line_window_buffer #(
    parameter int BufferWidth   = 8,
    parameter int MaxDelay      = 8,   // >= 2
    parameter int BufferRows    = 3,   // >= 2
    parameter int WindowCols    = 3,   // >= 1
    parameter int InputChannels = 2
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic [InputChannels-1:0][BufferWidth-1:0]     data_i,
    input  logic                                          sof_i,
    input  logic [$clog2(MaxDelay+1)-1:0]                 line_len_i,
    input  logic                                          valid_i,
    output logic                                          ready_o,
    output logic [InputChannels-1:0][BufferRows-1:0][WindowCols-1:0][BufferWidth-1:0] data_o,
    output logic                                          window_full_o,
    output logic                                          valid_o,
    input  logic                                          ready_i
);

    localparam int LenW   = $clog2(MaxDelay + 1);
    localparam int AddrW  = $clog2(MaxDelay);
    localparam int RowW   = $clog2(BufferRows);
    localparam int StRows = BufferRows - 1;

    localparam logic [LenW-1:0] LenMin = LenW'(2);
    localparam logic [LenW-1:0] LenMax = LenW'(MaxDelay);
    localparam logic [LenW-1:0] LenOne = LenW'(1);
    localparam logic [RowW-1:0] RowMax = RowW'(BufferRows - 1);
    localparam logic [RowW-1:0] RowOne = RowW'(1);

    typedef logic [InputChannels-1:0][BufferWidth-1:0]                             pix_t;
    typedef logic [InputChannels-1:0][StRows-1:0][BufferWidth-1:0]                 stcol_t;
    typedef logic [InputChannels-1:0][BufferRows-1:0][BufferWidth-1:0]             fullcol_t;
    typedef logic [InputChannels-1:0][BufferRows-1:0][WindowCols-1:0][BufferWidth-1:0] win_t;

    // Line RAM and its registered read port
    stcol_t mem_q [MaxDelay];
    stcol_t rd_q;
    stcol_t wr_col;

    // Frame position of the next beat. ptr_q is both the RAM address and the
    // column count: both restart on sof and wrap at len_q.
    logic [LenW-1:0] len_q, len_d;
    logic [LenW-1:0] ptr_q, ptr_d;
    logic [RowW-1:0] row_q, row_d;

    // Position of the beat currently offered on the input
    logic [LenW-1:0] len_clamp;
    logic [LenW-1:0] beat_col;
    logic [RowW-1:0] beat_row;
    logic            beat_last;

    // S1 stage
    logic            s1_valid_q;
    pix_t            s1_pix_q;
    logic [LenW-1:0] s1_col_q;
    logic [RowW-1:0] s1_row_q;

    // OUT stage
    logic            out_valid_q;
    win_t            win_q, win_d;
    logic            full_q, full_d;
    fullcol_t        cur_col;

    logic accept;
    logic advance;

    assign ready_o = !s1_valid_q || !out_valid_q || ready_i;
    assign accept  = valid_i && ready_o;
    // Any accept while S1 is occupied implies S1 advances in the same edge.
    assign advance = s1_valid_q && (!out_valid_q || ready_i);

    assign data_o        = win_q;
    assign window_full_o = full_q;
    assign valid_o       = out_valid_q;

    // -----------------------------------------------------------------------
    // Input beat position and next frame position
    // -----------------------------------------------------------------------
    always_comb begin
        len_clamp = line_len_i;
        if (line_len_i < LenMin) begin
            len_clamp = LenMin;
        end else if (line_len_i > LenMax) begin
            len_clamp = LenMax;
        end

        len_d    = sof_i ? len_clamp : len_q;
        beat_col = sof_i ? '0 : ptr_q;
        beat_row = sof_i ? '0 : row_q;

        beat_last = (beat_col == len_d - LenOne);
        ptr_d     = beat_last ? '0 : beat_col + LenOne;
        row_d     = (beat_last && beat_row != RowMax) ? beat_row + RowOne : beat_row;
    end

    // -----------------------------------------------------------------------
    // Window assembly for the S1 beat, and the column written back to RAM
    // -----------------------------------------------------------------------
    always_comb begin
        cur_col = '0;
        wr_col  = '0;
        win_d   = '0;
        for (int ch = 0; ch < InputChannels; ch++) begin
            cur_col[ch][0] = s1_pix_q[ch];
            for (int r = 1; r < BufferRows; r++) begin
                cur_col[ch][r] = rd_q[ch][r-1];
            end

            // Newest pixel enters slot 0, oldest stored line drops off.
            wr_col[ch][0] = s1_pix_q[ch];
            for (int r = 1; r < StRows; r++) begin
                wr_col[ch][r] = rd_q[ch][r-1];
            end

            for (int r = 0; r < BufferRows; r++) begin
                win_d[ch][r][0] = cur_col[ch][r];
                for (int c = 1; c < WindowCols; c++) begin
                    win_d[ch][r][c] = win_q[ch][r][c-1];
                end
                // Rows/columns not yet reached in this frame/line read as zero,
                // hiding stale RAM contents and the previous line's pixels.
                for (int c = 0; c < WindowCols; c++) begin
                    if (r > int'(s1_row_q) || c > int'(s1_col_q)) begin
                        win_d[ch][r][c] = '0;
                    end
                end
            end
        end
        full_d = (s1_row_q == RowMax) && (int'(s1_col_q) >= WindowCols - 1);
    end

    // -----------------------------------------------------------------------
    // Control and pipeline registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_pix_q    <= '0;
            s1_col_q    <= '0;
            s1_row_q    <= '0;
            out_valid_q <= 1'b0;
            win_q       <= '0;
            full_q      <= 1'b0;
            ptr_q       <= '0;
            row_q       <= '0;
            len_q       <= LenMax;
        end else begin
            if (accept) begin
                s1_valid_q <= 1'b1;
                s1_pix_q   <= data_i;
                s1_col_q   <= beat_col;
                s1_row_q   <= beat_row;
                len_q      <= len_d;
                ptr_q      <= ptr_d;
                row_q      <= row_d;
            end else if (advance) begin
                s1_valid_q <= 1'b0;
            end

            if (advance) begin
                out_valid_q <= 1'b1;
                win_q       <= win_d;
                full_q      <= full_d;
            end else if (ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Line RAM. Read and write addresses differ in any edge where both happen
    // (line length >= 2), except right after sof where the read data is masked.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (accept && !rst_i) begin
            rd_q <= mem_q[beat_col[AddrW-1:0]];
        end
        if (advance && !rst_i) begin
            mem_q[s1_col_q[AddrW-1:0]] <= wr_col;
        end
    end

endmodule

// File: tb/tb_line_window_buffer.sv
module tb_line_window_buffer;

    typedef logic [1:0][2:0][2:0][7:0] win_t;
    typedef struct packed {
        win_t        w;
        logic        f;
        logic [31:0] cyc;
    } exp_t;
    typedef struct packed {
        logic [7:0]      idx;
        logic [8:0]      m;     // bit k (= row*3+col) set: position holds real data
        logic [8:0][7:0] v;     // ch0 value at position k
        logic            full;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0][7:0] data_i;
    logic            sof_i;
    logic [3:0]      line_len_i;
    logic            valid_i;
    logic            ready_o;
    win_t            data_o;
    logic            window_full_o;
    logic            valid_o;
    logic            ready_i;

    line_window_buffer #(
        .BufferWidth(8), .MaxDelay(8), .BufferRows(3), .WindowCols(3), .InputChannels(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .data_i(data_i), .sof_i(sof_i),
        .line_len_i(line_len_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_o(data_o), .window_full_o(window_full_o), .valid_o(valid_o),
        .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame position plus the last few lines of pixels
    exp_t       q[$];
    logic [7:0] img [4][8][2];
    int         m_line, m_col, m_len;
    logic [31:0] cyc = 0;
    logic       lat_chk = 1'b0;

    win_t       cap_win [64];
    logic       cap_full [64];
    int         cap_n;
    int         acc_cnt;

    // Directed stream driver state
    logic [7:0] pix, npix, sof_at;
    logic [3:0] len;
    logic       sof_pend;

    vec_t tbl [7];

    task automatic check(input string nm, input logic [143:0] got, input logic [143:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic int clamp_len(input int l);
        if (l < 2) return 2;
        if (l > 8) return 8;
        return l;
    endfunction

    // A window position (r,c) shows the pixel r lines up and c pixels left of
    // the current one when that pixel exists in this frame, else zero.
    function automatic void model_accept(input logic [1:0][7:0] d, input logic s, input logic [3:0] l);
        exp_t e;
        int   ln, cl;
        if (s) begin
            m_line = 0;
            m_col  = 0;
            m_len  = clamp_len(int'(l));
        end
        img[m_line % 4][m_col][0] = d[0];
        img[m_line % 4][m_col][1] = d[1];
        e.w = '0;
        for (int ch = 0; ch < 2; ch++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    ln = m_line - r;
                    cl = m_col - c;
                    if (ln >= 0 && cl >= 0) e.w[ch][r][c] = img[ln % 4][cl][ch];
                end
        e.f   = (m_line >= 2) && (m_col >= 2);
        e.cyc = cyc;
        q.push_back(e);
        m_col++;
        if (m_col == m_len) begin
            m_col = 0;
            m_line++;
        end
    endfunction

    // One clock: evaluate both handshakes mid-cycle, then cross the edge.
    task automatic tick();
        logic fire, acc, r;
        exp_t e;
        @(negedge clk);
        r    = rst;
        fire = valid_o && ready_i;
        acc  = valid_i && ready_o && !r;
        if (fire) begin
            check("out_expected", q.size() > 0, 1'b1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("window", data_o, e.w);
                check("full", window_full_o, e.f);
                if (lat_chk) check("latency", cyc - e.cyc, 32'd2);
            end
            if (cap_n < 64) begin
                cap_win[cap_n]  = data_o;
                cap_full[cap_n] = window_full_o;
                cap_n++;
            end
        end
        if (acc) begin
            model_accept(data_i, sof_i, line_len_i);
            acc_cnt++;
            pix++;
            sof_pend = 1'b0;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (r) begin
            q.delete();
            m_line = 0;
            m_col  = 0;
            m_len  = 8;
        end
    endtask

    task automatic drive();
        valid_i    = (pix < npix);
        data_i     = {pix + 8'h80, pix};
        sof_i      = sof_pend || (pix == sof_at);
        line_len_i = len;
    endtask

    task automatic start_stream(input logic [7:0] n, input logic [3:0] l, input logic [7:0] sa);
        pix      = 0;
        npix     = n;
        len      = l;
        sof_at   = sa;
        sof_pend = 1'b1;
        cap_n    = 0;
    endtask

    task automatic run_until_done(input string nm);
        for (int i = 0; i < 80 && !(pix == npix && q.size() == 0); i++) begin
            drive();
            tick();
        end
        check(nm, (pix == npix) && (q.size() == 0), 1'b1);
        valid_i = 1'b0;
        sof_i   = 1'b0;
    endtask

    task automatic run_frame32();
        ready_i = 1'b1;
        start_stream(8'd12, 4'd4, 8'hFF);
        lat_chk = 1'b1;
        run_until_done("frame_done");
        lat_chk = 1'b0;
    endtask

    function automatic win_t tbl_win(input vec_t t);
        win_t w = '0;
        for (int k = 0; k < 9; k++)
            if (t.m[k]) begin
                w[0][k/3][k%3] = t.v[k];
                w[1][k/3][k%3] = t.v[k] + 8'h80;
            end
        return w;
    endfunction

    task automatic check_table();
        for (int i = 0; i < 7; i++) begin
            check($sformatf("tbl_win_px%0d", tbl[i].idx), cap_win[tbl[i].idx], tbl_win(tbl[i]));
            check($sformatf("tbl_full_px%0d", tbl[i].idx), cap_full[tbl[i].idx], tbl[i].full);
        end
    endtask

    initial begin
        win_t held, expw;

        // Frame: line_len 4, pixels 0..11. v listed from position 8 down to 0.
        tbl[0] = '{idx: 8'd0,  m: 9'b000000001, full: 1'b0,
                   v: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}};
        tbl[1] = '{idx: 8'd3,  m: 9'b000000111, full: 1'b0,
                   v: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3}};
        tbl[2] = '{idx: 8'd5,  m: 9'b000011011, full: 1'b0,
                   v: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd4, 8'd5}};
        tbl[3] = '{idx: 8'd8,  m: 9'b001001001, full: 1'b0,
                   v: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd4, 8'd0, 8'd0, 8'd8}};
        tbl[4] = '{idx: 8'd9,  m: 9'b011011011, full: 1'b0,
                   v: {8'd0, 8'd0, 8'd1, 8'd0, 8'd4, 8'd5, 8'd0, 8'd8, 8'd9}};
        tbl[5] = '{idx: 8'd10, m: 9'b111111111, full: 1'b1,
                   v: {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10}};
        tbl[6] = '{idx: 8'd11, m: 9'b111111111, full: 1'b1,
                   v: {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11}};

        m_line = 0; m_col = 0; m_len = 8;
        cap_n = 0; acc_cnt = 0;
        pix = 0; npix = 0; sof_at = 8'hFF; len = 4'd4; sof_pend = 1'b0;
        rst = 1'b1; valid_i = 1'b0; sof_i = 1'b0; data_i = '0;
        line_len_i = '0; ready_i = 1'b1;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid_o", valid_o, 1'b0);
        check("rst_ready_o", ready_o, 1'b1);
        check("rst_full", window_full_o, 1'b0);
        check("rst_data", data_o, '0);

        // Basic frame with full-rate output
        run_frame32();
        check_table();

        // Output stall mid-stream
        ready_i = 1'b1;
        start_stream(8'd12, 4'd4, 8'hFF);
        for (int i = 0; i < 20 && pix < 6; i++) begin
            drive();
            tick();
        end
        ready_i = 1'b0;
        held    = data_o;
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            drive();
            tick();
            check("stall_valid", valid_o, 1'b1);
            check("stall_hold", data_o, held);
        end
        check("stall_accepts_le2", acc_cnt <= 2, 1'b1);
        ready_i = 1'b1;
        run_until_done("stall_done");

        // Line length clamping: 1 -> 2
        start_stream(8'd10, 4'd1, 8'hFF);
        run_until_done("clamp_lo_done");
        check("clamp_lo_px2_row1", cap_win[2][1][1][0], 8'h80);
        check("clamp_lo_px4_row2", cap_win[4][1][2][0], 8'h80);
        // 12 -> 8
        start_stream(8'd10, 4'd12, 8'hFF);
        run_until_done("clamp_hi_done");
        check("clamp_hi_px7_row1", cap_win[7][1][1], 24'h0);
        check("clamp_hi_px8_row1", cap_win[8][1][1][0], 8'h80);

        // sof at column 2 of line 1
        start_stream(8'd10, 4'd4, 8'd6);
        run_until_done("midsof_done");
        expw = '0;
        expw[0][0][0] = 8'd6;
        expw[1][0][0] = 8'h86;
        check("midsof_win", cap_win[6], expw);
        check("midsof_full", cap_full[6], 1'b0);

        // Reset with both stages occupied
        ready_i = 1'b0;
        start_stream(8'd12, 4'd4, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            drive();
            tick();
        end
        check("prerst_valid_o", valid_o, 1'b1);
        check("prerst_ready_o", ready_o, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        valid_i = 1'b0;
        check("postrst_valid_o", valid_o, 1'b0);
        check("postrst_ready_o", ready_o, 1'b1);
        run_frame32();
        check_table();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            valid_i    = ($urandom_range(0, 9) < 7);
            ready_i    = ($urandom_range(0, 9) < 7);
            sof_i      = ($urandom_range(0, 29) == 0);
            line_len_i = 4'($urandom_range(0, 15));
            data_i     = 16'($urandom);
            tick();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("drain_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
